// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: merges N_SRC AXI-Stream sources into one stream, granting fixed-length
// packets round-robin with one idle cycle between packets.
module axis_rr_arbiter #(
    parameter int N_SRC   = 4,
    parameter int WORD_W  = 8,
    parameter int BUS_W   = 8,
    parameter int N_BEATS = 10,
    localparam int WPB    = BUS_W / WORD_W,
    localparam int SW     = $clog2(N_SRC),
    localparam int CW     = $clog2(N_BEATS + 1)
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [N_SRC-1:0]                        s_valid,
    output logic [N_SRC-1:0]                        s_ready,
    input  logic [N_SRC-1:0][WPB-1:0][WORD_W-1:0]   s_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [WPB-1:0][WORD_W-1:0]              m_data,
    output logic [SW-1:0]                           m_src,
    output logic                                    busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] src_q, src_d, last_q, last_d, win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;

    assign busy    = state_q == BUSY;
    assign m_src   = src_q;
    assign m_valid = busy & s_valid[src_q];
    assign m_data  = busy ? s_data[src_q] : 'x;
    assign xfer    = m_valid & m_ready;

    always_comb begin
        s_ready = '0;
        if (busy) s_ready[src_q] = m_ready;
    end

    // Scan downward so the nearest requester after last is the final assignment.
    always_comb begin
        win = src_q;
        for (int i = N_SRC; i >= 1; i--)
            if (s_valid[(int'(last_q) + i) % N_SRC]) win = SW'((int'(last_q) + i) % N_SRC);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (|s_valid) begin
                state_d = BUSY;
                src_d   = win;
                cnt_d   = '0;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N_BEATS - 1)) begin
                state_d = IDLE;
                last_d  = src_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            src_q   <= '0;
            last_q  <= SW'(N_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: grant-order vector table plus directed corner cases and a random
// traffic run, with per-source expected-data queues checked on every merged beat.
module tb_axis_rr_arbiter;
    localparam int N_SRC   = 4;
    localparam int WORD_W  = 8;
    localparam int BUS_W   = 8;
    localparam int N_BEATS = 10;
    localparam int WPB     = BUS_W / WORD_W;
    localparam int PKTS    = 50;

    logic                                  clk = 0;
    logic                                  rstn = 0;
    logic [N_SRC-1:0]                      s_valid = '0;
    logic [N_SRC-1:0]                      s_ready;
    logic [N_SRC-1:0][WPB-1:0][WORD_W-1:0] s_data;
    logic                                  m_valid;
    logic                                  m_ready = 0;
    logic [WPB-1:0][WORD_W-1:0]            m_data;
    logic [1:0]                            m_src;
    logic                                  busy;

    axis_rr_arbiter #(.N_SRC(N_SRC), .WORD_W(WORD_W), .BUS_W(BUS_W), .N_BEATS(N_BEATS)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src(m_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] valid;
        logic [1:0] src;
    } vec_t;

    vec_t             tbl [13];
    logic [BUS_W-1:0] exp_q [N_SRC][$];
    int               grants[$];
    int               grant_cyc[$];
    int               rx_cnt [N_SRC];
    int               tests = 0, fails = 0, cyc = 0, pkt_beats = 0, pkt_src = 0;
    bit               prev_busy = 0, hold = 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock: sample and check at negedge, then update stimulus just after posedge.
    task automatic step();
        int   nhs, hs_src;
        logic last_beat;
        @(negedge clk);
        cyc++;
        nhs = 0;
        hs_src = 0;
        last_beat = 0;
        if (!rstn) begin
            chk("rst_busy", busy, 0);
            chk("rst_mvalid", m_valid, 0);
            chk("rst_sready", s_ready, 0);
            chk("rst_msrc", m_src, 0);
            prev_busy = 0;
        end else begin
            for (int s = 0; s < N_SRC; s++)
                if (s_valid[s] && s_ready[s]) begin
                    nhs++;
                    hs_src = s;
                end
            if (busy && !prev_busy) begin
                pkt_src = m_src;
                pkt_beats = 0;
                grants.push_back(int'(m_src));
                grant_cyc.push_back(cyc);
            end
            if (busy) begin
                chk("src_stable", m_src, pkt_src);
                chk("mvalid", m_valid, s_valid[pkt_src]);
                chk("sready", s_ready, 32'(m_ready) << pkt_src);
            end else begin
                chk("idle_mvalid", m_valid, 0);
                chk("idle_sready", s_ready, 0);
                if (prev_busy) chk("pkt_beats", pkt_beats, N_BEATS);
            end
            if (busy && m_valid && m_ready) begin
                chk("hs_count", nhs, 1);
                chk("hs_src", hs_src, pkt_src);
                if (exp_q[pkt_src].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dup_beat: src %0d got %0h expected no beat", pkt_src, m_data);
                end else chk("data", m_data, exp_q[pkt_src].pop_front());
                pkt_beats++;
                rx_cnt[pkt_src]++;
                last_beat = pkt_beats == N_BEATS;
            end else chk("hs_none", nhs, 0);
            prev_busy = busy;
        end
        @(posedge clk);
        #1;
        if (nhs == 1) begin
            s_data[hs_src] = BUS_W'($urandom);
            exp_q[hs_src].push_back(s_data[hs_src]);
        end
        if (last_beat && hold) s_valid = '0;
    endtask

    task automatic wait_grants(int n, int lim);
        int k = 0;
        while (grants.size() < n && k < lim) begin
            step();
            k++;
        end
        chk("grant_timeout", grants.size() >= n, 1);
    endtask

    task automatic wait_idle(int lim);
        int k = 0;
        while (prev_busy && k < lim) begin
            step();
            k++;
        end
        chk("idle_timeout", prev_busy, 0);
    endtask

    task automatic wait_beats(int b);
        int k = 0;
        while (pkt_beats != b && k < 100) begin
            step();
            k++;
        end
        chk("beat_timeout", pkt_beats, b);
    endtask

    task automatic expect_grant(string name, int src);
        int n = grants.size();
        wait_grants(n + 1, 30);
        if (grants.size() > n) chk(name, grants[n], src);
    endtask

    initial begin
        int k;
        bit done;
        tbl = '{
            '{4'b0100, 2'd2}, '{4'b0100, 2'd2}, '{4'b1001, 2'd3}, '{4'b1001, 2'd0},
            '{4'b0010, 2'd1}, '{4'b1010, 2'd3}, '{4'b0011, 2'd0}, '{4'b0011, 2'd1},
            '{4'b1111, 2'd2}, '{4'b0001, 2'd0}, '{4'b1000, 2'd3}, '{4'b0110, 2'd1},
            '{4'b0001, 2'd0}
        };
        for (int s = 0; s < N_SRC; s++) begin
            s_data[s] = BUS_W'($urandom);
            exp_q[s].push_back(s_data[s]);
            rx_cnt[s] = 0;
        end
        step();
        step();
        rstn = 1;

        // All sources requesting: strict rotation from source 0, 11 cycles per packet.
        hold = 0;
        s_valid = '1;
        m_ready = 1;
        wait_grants(5, 70);
        hold = 1;
        wait_idle(20);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rot_grant", grants[i], i % N_SRC);
        for (int i = 0; i < 4 && i + 1 < grant_cyc.size(); i++)
            chk("rot_spacing", grant_cyc[i+1] - grant_cyc[i], N_BEATS + 1);

        foreach (tbl[i]) begin
            s_valid = tbl[i].valid;
            m_ready = 1;
            expect_grant("tbl_grant", int'(tbl[i].src));
            wait_idle(60);
        end

        // Source 0 joins while source 1 holds the grant; it wins only after the packet.
        hold = 0;
        s_valid = 4'b0010;
        expect_grant("late_grant1", 1);
        wait_beats(3);
        s_valid = 4'b0011;
        expect_grant("late_next0", 0);
        hold = 1;
        wait_idle(60);

        // Downstream stall mid-packet: output holds the source beat and the grant.
        s_valid = 4'b0100;
        expect_grant("stall_grant", 2);
        wait_beats(4);
        m_ready = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, s_data[2]);
            chk("stall_src", m_src, 2);
            chk("stall_beats", pkt_beats, 4);
        end
        m_ready = 1;
        wait_idle(60);

        // Reset mid-packet aborts immediately; arbitration restarts from source 0.
        s_valid = 4'b1000;
        expect_grant("abort_grant", 3);
        wait_beats(5);
        rstn = 0;
        #1;
        chk("abort_mvalid", m_valid, 0);
        chk("abort_sready", s_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_msrc", m_src, 0);
        step();
        step();
        s_valid = 4'b1010;
        rstn = 1;
        expect_grant("post_rst_grant", 1);
        wait_idle(60);

        // Random traffic: each source sends PKTS packets, data order checked per source.
        hold = 0;
        for (int s = 0; s < N_SRC; s++) rx_cnt[s] = 0;
        k = 0;
        done = 0;
        while (!done && k < 40000) begin
            for (int s = 0; s < N_SRC; s++)
                s_valid[s] = rx_cnt[s] < PKTS * N_BEATS && $urandom_range(99) >= 30;
            m_ready = $urandom_range(99) >= 30;
            step();
            k++;
            done = 1;
            for (int s = 0; s < N_SRC; s++) if (rx_cnt[s] < PKTS * N_BEATS) done = 0;
        end
        s_valid = '0;
        step();
        step();
        for (int s = 0; s < N_SRC; s++) begin
            chk("rand_beats", rx_cnt[s], PKTS * N_BEATS);
            chk("rand_pending", exp_q[s].size(), 1);
        end
        chk("rand_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
